// File: rtl/closest_hit_selector.sv
// -----------------------------------------------------------------------------
// closest_hit_selector
//
// Sits directly behind the intersection stage. For each ray it sees the
// per-triangle results one at a time and keeps the nearest valid hit, which
// is the smallest positive t. When the last triangle of the ray has been
// merged it publishes a single nearest-hit record to the shading stage.
//
// All values use the fixed format: 32-bit signed Q4.28, fixed(1) = 0x10000000.
//
// Parameters
//   IDW       width of the triangle index and of the tested-triangle counter
//   HIT_CODE  intersection code that marks a valid hit
//   T_MIN     self-intersection epsilon; a hit is rejected when t <= T_MIN
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-low reset
//   ray_start     one-cycle pulse: begin a new ray and clear the accumulation
//   hit_valid     one-cycle pulse: sample the hit_* inputs
//   hit_code      intersection code
//   hit_t         ray parameter t (fixed)
//   hit_u/hit_v   barycentrics (fixed)
//   hit_id        index of the triangle that produced this result
//   hit_last      qualifies hit_valid: last triangle of the ray
//   busy          high while a ray is being accumulated
//   result_valid  one-cycle pulse: result_* carry a new record
//   result_hit    at least one hit was accepted for the ray
//   result_t/u/v  nearest hit (held until the next record)
//   result_id     index of the nearest triangle (held)
//   result_count  results sampled for the ray, rejected ones included (held)
// -----------------------------------------------------------------------------
module closest_hit_selector #(
    parameter int          IDW      = 16,
    parameter logic [1:0]  HIT_CODE = 2'd1,
    parameter logic [31:0] T_MIN    = 32'h00040000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ray_start,
    input  logic            hit_valid,
    input  logic [1:0]      hit_code,
    input  logic [31:0]     hit_t,
    input  logic [31:0]     hit_u,
    input  logic [31:0]     hit_v,
    input  logic [IDW-1:0]  hit_id,
    input  logic            hit_last,
    output logic            busy,
    output logic            result_valid,
    output logic            result_hit,
    output logic [31:0]     result_t,
    output logic [31:0]     result_u,
    output logic [31:0]     result_v,
    output logic [IDW-1:0]  result_id,
    output logic [IDW-1:0]  result_count
);

    // "No hit yet" distance: the largest positive fixed value. A sample at
    // exactly this t can never be strictly closer, so it is never accepted.
    localparam logic [31:0]    T_FAR     = 32'h7FFFFFFF;
    localparam logic [IDW-1:0] COUNT_MAX = {IDW{1'b1}};
    localparam logic [IDW-1:0] COUNT_ONE = {{(IDW-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0] ID_ZERO   = {IDW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;

    // Running best hit of the ray under accumulation.
    logic [31:0]     best_t_r;
    logic [31:0]     best_u_r;
    logic [31:0]     best_v_r;
    logic [IDW-1:0]  best_id_r;
    logic            best_found_r;
    logic [IDW-1:0]  count_r;

    // Published record and status outputs.
    logic            busy_r;
    logic            result_valid_r;
    logic            result_hit_r;
    logic [31:0]     result_t_r;
    logic [31:0]     result_u_r;
    logic [31:0]     result_v_r;
    logic [IDW-1:0]  result_id_r;
    logic [IDW-1:0]  result_count_r;

    // Per-sample decode.
    logic            sample_s;
    logic            code_ok_s;
    logic            beyond_eps_s;
    logic            closer_s;
    logic            accept_s;
    logic [IDW-1:0]  count_inc_s;

    // Next-state logic; ray_start overrides everything, including DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ray_start) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (ray_start) begin
                    state_next_s = ST_ACCUM;
                end else if (hit_valid && hit_last) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (ray_start) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Sample qualification and accept decision for the current hit inputs.
    always_comb begin
        sample_s     = 1'b0;
        code_ok_s    = 1'b0;
        beyond_eps_s = 1'b0;
        closer_s     = 1'b0;
        accept_s     = 1'b0;
        count_inc_s  = count_r;

        // A sample coinciding with ray_start belongs to no ray and is dropped.
        if ((state_r == ST_ACCUM) && hit_valid && !ray_start) begin
            sample_s = 1'b1;
        end else begin
            sample_s = 1'b0;
        end

        if (hit_code == HIT_CODE) begin
            code_ok_s = 1'b1;
        end else begin
            code_ok_s = 1'b0;
        end

        // Both distance tests are signed so that negative t is rejected.
        if ($signed(hit_t) > $signed(T_MIN)) begin
            beyond_eps_s = 1'b1;
        end else begin
            beyond_eps_s = 1'b0;
        end

        // Strictly closer: on a tie the earlier triangle is kept.
        if ($signed(hit_t) < $signed(best_t_r)) begin
            closer_s = 1'b1;
        end else begin
            closer_s = 1'b0;
        end

        if (sample_s && code_ok_s && beyond_eps_s && closer_s) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end

        // The counter sticks at its maximum rather than wrapping.
        if (count_r != COUNT_MAX) begin
            count_inc_s = count_r + COUNT_ONE;
        end else begin
            count_inc_s = count_r;
        end
    end

    // State register and busy flag (busy mirrors the ACCUM state).
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_ACCUM);
        end
    end

    // Running best-hit accumulation for the current ray.
    always_ff @(posedge clock) begin
        if (!reset) begin
            best_t_r     <= T_FAR;
            best_u_r     <= 32'h00000000;
            best_v_r     <= 32'h00000000;
            best_id_r    <= ID_ZERO;
            best_found_r <= 1'b0;
            count_r      <= ID_ZERO;
        end else if (ray_start) begin
            best_t_r     <= T_FAR;
            best_u_r     <= 32'h00000000;
            best_v_r     <= 32'h00000000;
            best_id_r    <= ID_ZERO;
            best_found_r <= 1'b0;
            count_r      <= ID_ZERO;
        end else if (sample_s) begin
            count_r <= count_inc_s;
            if (accept_s) begin
                best_t_r     <= hit_t;
                best_u_r     <= hit_u;
                best_v_r     <= hit_v;
                best_id_r    <= hit_id;
                best_found_r <= 1'b1;
            end
        end
    end

    // Publish the record while in DONE; the result registers hold otherwise.
    // The DONE copy uses the pre-clear best state, so a ray_start arriving
    // in DONE still reports the finished ray.
    always_ff @(posedge clock) begin
        if (!reset) begin
            result_valid_r <= 1'b0;
            result_hit_r   <= 1'b0;
            result_t_r     <= T_FAR;
            result_u_r     <= 32'h00000000;
            result_v_r     <= 32'h00000000;
            result_id_r    <= ID_ZERO;
            result_count_r <= ID_ZERO;
        end else if (state_r == ST_DONE) begin
            result_valid_r <= 1'b1;
            result_hit_r   <= best_found_r;
            result_count_r <= count_r;
            if (best_found_r) begin
                result_t_r  <= best_t_r;
                result_u_r  <= best_u_r;
                result_v_r  <= best_v_r;
                result_id_r <= best_id_r;
            end else begin
                result_t_r  <= T_FAR;
                result_u_r  <= 32'h00000000;
                result_v_r  <= 32'h00000000;
                result_id_r <= ID_ZERO;
            end
        end else begin
            result_valid_r <= 1'b0;
        end
    end

    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign result_hit   = result_hit_r;
    assign result_t     = result_t_r;
    assign result_u     = result_u_r;
    assign result_v     = result_v_r;
    assign result_id    = result_id_r;
    assign result_count = result_count_r;

endmodule

// File: tb/tb_closest_hit_selector.sv
// -----------------------------------------------------------------------------
// tb_closest_hit_selector
//
// Directed scenarios followed by random rays. Expected records come from a
// reference model that keeps each ray's samples in a queue and, at the end of
// the ray, picks the earliest sample with the smallest qualifying t.
// -----------------------------------------------------------------------------
module tb_closest_hit_selector;

    localparam logic [31:0] T_MIN = 32'h00040000;
    localparam logic [31:0] T_FAR = 32'h7FFFFFFF;

    logic        clock;
    logic        reset;
    logic        ray_start;
    logic        hit_valid;
    logic [1:0]  hit_code;
    logic [31:0] hit_t;
    logic [31:0] hit_u;
    logic [31:0] hit_v;
    logic [15:0] hit_id;
    logic        hit_last;
    logic        busy;
    logic        result_valid;
    logic        result_hit;
    logic [31:0] result_t;
    logic [31:0] result_u;
    logic [31:0] result_v;
    logic [15:0] result_id;
    logic [15:0] result_count;

    closest_hit_selector dut (
        .clock        (clock),
        .reset        (reset),
        .ray_start    (ray_start),
        .hit_valid    (hit_valid),
        .hit_code     (hit_code),
        .hit_t        (hit_t),
        .hit_u        (hit_u),
        .hit_v        (hit_v),
        .hit_id       (hit_id),
        .hit_last     (hit_last),
        .busy         (busy),
        .result_valid (result_valid),
        .result_hit   (result_hit),
        .result_t     (result_t),
        .result_u     (result_u),
        .result_v     (result_v),
        .result_id    (result_id),
        .result_count (result_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] t;
        logic [31:0] u;
        logic [31:0] v;
        logic [15:0] id;
    } sample_t;

    sample_t     ray_q[$];
    int          n_pass;
    int          n_total;
    logic        exp_hit;
    logic [31:0] exp_t;
    logic [31:0] exp_u;
    logic [31:0] exp_v;
    logic [15:0] exp_id;
    logic [15:0] exp_count;

    // Nearest qualifying sample of the ray; the first one wins a tie.
    function automatic void model_eval();
        int best;
        best = -1;
        for (int i = 0; i < ray_q.size(); i++) begin
            if (ray_q[i].code == 2'd1 && $signed(ray_q[i].t) > $signed(T_MIN)
                && ray_q[i].t != T_FAR) begin
                if (best < 0) begin
                    best = i;
                end else if ($signed(ray_q[i].t) < $signed(ray_q[best].t)) begin
                    best = i;
                end
            end
        end
        exp_count = (ray_q.size() > 65535) ? 16'hFFFF : 16'(ray_q.size());
        if (best < 0) begin
            exp_hit = 1'b0;
            exp_t   = T_FAR;
            exp_u   = 32'h0;
            exp_v   = 32'h0;
            exp_id  = 16'h0;
        end else begin
            exp_hit = 1'b1;
            exp_t   = ray_q[best].t;
            exp_u   = ray_q[best].u;
            exp_v   = ray_q[best].v;
            exp_id  = ray_q[best].id;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'h0);
        check({tag, "_valid"}, 32'(result_valid), 32'h0);
        check({tag, "_hit"},   32'(result_hit), 32'h0);
        check({tag, "_t"},     result_t, T_FAR);
        check({tag, "_u"},     result_u, 32'h0);
        check({tag, "_v"},     result_v, 32'h0);
        check({tag, "_id"},    32'(result_id), 32'h0);
        check({tag, "_count"}, 32'(result_count), 32'h0);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_valid"}, 32'(result_valid), 32'h1);
        check({tag, "_hit"},   32'(result_hit), 32'(exp_hit));
        check({tag, "_t"},     result_t, exp_t);
        check({tag, "_u"},     result_u, exp_u);
        check({tag, "_v"},     result_v, exp_v);
        check({tag, "_id"},    32'(result_id), 32'(exp_id));
        check({tag, "_count"}, 32'(result_count), 32'(exp_count));
    endtask

    task automatic start_ray();
        ray_start = 1'b1;
        tick();
        ray_start = 1'b0;
        ray_q.delete();
        check("busy_after_start", 32'(busy), 32'h1);
    endtask

    task automatic send(input logic [1:0] code, input logic [31:0] t, input logic [31:0] u,
                        input logic [31:0] v, input logic [15:0] id, input logic last);
        sample_t s;
        s.code = code; s.t = t; s.u = u; s.v = v; s.id = id;
        hit_valid = 1'b1;
        hit_code  = code;
        hit_t     = t;
        hit_u     = u;
        hit_v     = v;
        hit_id    = id;
        hit_last  = last;
        ray_q.push_back(s);
        tick();
        hit_valid = 1'b0;
        hit_last  = 1'b0;
        check("busy_after_sample", 32'(busy), last ? 32'h0 : 32'h1);
    endtask

    // Called right after the edge that sampled the last result: the record
    // appears one cycle later and is then held.
    task automatic finish_ray(input string tag);
        check({tag, "_no_early_valid"}, 32'(result_valid), 32'h0);
        model_eval();
        tick();
        check_result(tag);
        tick();
        check({tag, "_valid_drop"}, 32'(result_valid), 32'h0);
        check({tag, "_t_held"},     result_t, exp_t);
    endtask

    function automatic logic [31:0] rand_t();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'h08000000;
            2:       return {4'hF, 28'($urandom)};
            3:       return 32'($urandom_range(32'h0003FFFE, 32'h00040002));
            default: return 32'($urandom_range(32'h00040001, 32'h00200000));
        endcase
    endfunction

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b0;
        ray_start = 1'b0;
        hit_valid = 1'b0;
        hit_code  = 2'd0;
        hit_t     = 32'h0;
        hit_u     = 32'h0;
        hit_v     = 32'h0;
        hit_id    = 16'h0;
        hit_last  = 1'b0;

        // Reset held low for two cycles.
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // hit_valid while idle is ignored.
        for (int i = 0; i < 3; i++) begin
            hit_valid = 1'b1;
            hit_code  = 2'd1;
            hit_t     = 32'h10000000;
            hit_last  = (i == 2);
            tick();
            hit_valid = 1'b0;
            hit_last  = 1'b0;
            check("idle_no_valid", 32'(result_valid), 32'h0);
        end
        tick();
        check("idle_no_valid_late", 32'(result_valid), 32'h0);
        check("idle_count", 32'(result_count), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);

        // Three results, the middle one nearest.
        start_ray();
        send(2'd1, 32'h20000000, 32'h01000000, 32'h02000000, 16'd0, 1'b0);
        send(2'd1, 32'h08000000, 32'h03000000, 32'h04000000, 16'd1, 1'b0);
        send(2'd1, 32'h10000000, 32'h05000000, 32'h06000000, 16'd2, 1'b1);
        finish_ray("three");
        check("three_spec_t", result_t, 32'h08000000);
        check("three_spec_id", 32'(result_id), 32'd1);

        // Every sample rejected.
        start_ray();
        send(2'd2, 32'h01000000, 32'h1, 32'h2, 16'd10, 1'b0);
        send(2'd1, 32'hF0000000, 32'h3, 32'h4, 16'd11, 1'b0);
        send(2'd1, 32'h00020000, 32'h5, 32'h6, 16'd12, 1'b0);
        send(2'd0, 32'h01000000, 32'h7, 32'h8, 16'd13, 1'b1);
        finish_ray("reject");
        check("reject_spec_count", 32'(result_count), 32'd4);

        // Epsilon boundary: exactly T_MIN rejected, T_MIN+1 accepted.
        start_ray();
        send(2'd1, T_MIN, 32'h9, 32'h9, 16'd20, 1'b0);
        send(2'd1, T_MIN + 32'h1, 32'hA, 32'hA, 16'd21, 1'b1);
        finish_ray("eps");

        // Ties keep the earlier triangle.
        start_ray();
        send(2'd1, 32'h08000000, 32'h08000000, 32'h08000000, 16'd5, 1'b0);
        send(2'd1, 32'h08000000, 32'h01000000, 32'h02000000, 16'd6, 1'b1);
        finish_ray("tie");
        check("tie_spec_id", 32'(result_id), 32'd5);

        // ray_start together with hit_valid discards the sample.
        hit_valid = 1'b1;
        hit_code  = 2'd1;
        hit_t     = 32'h01000000;
        hit_id    = 16'd30;
        start_ray();
        hit_valid = 1'b0;
        send(2'd1, 32'h20000000, 32'h11, 32'h22, 16'd31, 1'b1);
        finish_ray("start_collide");
        check("start_collide_count", 32'(result_count), 32'd1);

        // Reset in ACCUM after two accepted samples aborts the ray.
        start_ray();
        send(2'd1, 32'h04000000, 32'h1, 32'h1, 16'd40, 1'b0);
        send(2'd1, 32'h02000000, 32'h2, 32'h2, 16'd41, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_outputs("midreset");
        tick();
        tick();
        check("midreset_no_valid", 32'(result_valid), 32'h0);
        start_ray();
        send(2'd1, 32'h30000000, 32'h12, 32'h34, 16'd42, 1'b1);
        finish_ray("after_reset");

        // ray_start during DONE: old record still published, new ray begins.
        start_ray();
        send(2'd1, 32'h06000000, 32'h55, 32'h66, 16'd50, 1'b1);
        model_eval();
        ray_start = 1'b1;
        tick();
        ray_start = 1'b0;
        check_result("done_start");
        check("done_start_busy", 32'(busy), 32'h1);
        ray_q.delete();
        send(2'd1, 32'h07000000, 32'h77, 32'h88, 16'd51, 1'b1);
        finish_ray("done_start_next");

        // Random rays, with idle gaps and stray hit_last pulses.
        for (int r = 0; r < 30; r++) begin
            int n;
            start_ray();
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    hit_last = 1'b1;
                    tick();
                    hit_last = 1'b0;
                    check("rand_stray_last_busy", 32'(busy), 32'h1);
                end
                send(2'($urandom_range(0, 3)), rand_t(), $urandom, $urandom,
                     16'($urandom), (k == n - 1));
            end
            finish_ray("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/closest_hit_selector.md
# closest_hit_selector

Consumes the per-triangle results of `intersectionModule` for one ray and keeps the nearest valid hit, i.e. the smallest positive `t`. It sits directly downstream of the intersection stage in the coprocessor datapath. It accumulates results across the triangle list of a ray and emits one nearest-hit record per ray to the shading/output stage. Values use the codebase `fixed` format: 32-bit signed Q4.28, where `fixed(1)` = 0x10000000.

## Interface
Parameters:
- `IDW`, 16, width of triangle index and tested-triangle counter.
- `HIT_CODE`, 2'd1, value of the intersection `code` that denotes a valid hit.
- `T_MIN`, 32'h00040000 (≈0.001), self-intersection epsilon; hits with `t <= T_MIN` are rejected.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `ray_start`  in  1  one-cycle pulse; begins a new ray and clears accumulation.
- `hit_valid`  in  1  one-cycle pulse from the intersection `ready`; samples the `hit_*` inputs.
- `hit_code`  in  2  intersection code.
- `hit_t`  in  32  fixed; ray parameter `t`.
- `hit_u`, `hit_v`  in  32 each  fixed; barycentrics.
- `hit_id`  in  IDW  index of the triangle that produced this result.
- `hit_last`  in  1  qualifies `hit_valid`: this is the last triangle of the ray.
- `busy`  out  1  high while in ACCUM.
- `result_valid`  out  1  one-cycle pulse; the `result_*` outputs are valid.
- `result_hit`  out  1  at least one accepted hit for the ray.
- `result_t`, `result_u`, `result_v`  out  32 each  fixed; the nearest hit (held).
- `result_id`  out  IDW  index of the nearest triangle (held).
- `result_count`  out  IDW  number of results sampled for the ray, including rejected ones (held).

## Operation
- States:
  - IDLE: waits for `ray_start`; `hit_valid` is ignored.
  - ACCUM: on each `hit_valid`, samples the inputs.
  - DONE: one cycle; publishes the result.
- `ray_start`, from any state, goes to ACCUM and sets:
  - `best_t` = 32'h7FFFFFFF
  - `best_found` = 0
  - `count` = 0
- In ACCUM, a `hit_valid` sample does the following:
  - `count` increments, saturating at 2^IDW−1.
  - The sample is accepted iff all three hold: `hit_code == HIT_CODE`, signed `hit_t > T_MIN`, and signed `hit_t < best_t`.
  - On accept: `best_t/u/v/id` take the sample values and `best_found` is set to 1.
  - Ties (equal `t`) keep the earlier triangle.
  - Negative `t` and the codes for parallel, miss and behind-origin are all rejected.
- A `hit_valid` with `hit_last` in ACCUM is merged like any other sample, then the state goes to DONE.
- DONE:
  - Copies best state into the `result_*` registers and pulses `result_valid`.
  - If `best_found` is 0: `result_hit` = 0, `result_t` = 32'h7FFFFFFF, `result_u` = `result_v` = 0, `result_id` = 0.
  - Then goes to IDLE.
- `result_*` hold their values until the next DONE.
- Simultaneous events:
  - `ray_start` and `hit_valid` in the same cycle: `ray_start` wins and the sample is discarded.
  - `ray_start` during DONE: `result_valid` still pulses with the old ray's data, and the next state is ACCUM with cleared state.
- `hit_last` without `hit_valid` has no effect.
- Signed comparisons only; there is no arithmetic on values beyond copying and comparing.

## Timing
- Reset (`reset` low at a rising edge):
  - State goes to IDLE.
  - `busy`, `result_valid`, `result_hit`, `result_count`, `result_id`, `result_u`, `result_v` = 0.
  - `result_t` = 32'h7FFFFFFF.
  - Internal best state is cleared.
- Reset mid-ray aborts the ray with no `result_valid`.
- `busy` is high from the cycle after `ray_start` until the cycle the state leaves ACCUM.
- One sample per cycle is accepted; back-to-back `hit_valid` is legal.
- Latency: `result_valid` is high exactly 1 cycle after the edge that samples `hit_valid & hit_last`.
- No back-pressure; the consumer must take the result during the `result_valid` cycle or read the held registers later.

## Test plan
- Reset held low 2 cycles, then released:
  - All outputs at their reset values.
  - `hit_valid` pulses while IDLE leave `result_count` = 0 and produce no `result_valid`.
- Ray with 3 results:
  - (code 1, t=0x20000000, id 0), (code 1, t=0x08000000, id 1), (code 1, t=0x10000000, id 2, last).
  - Required: `result_valid` 1 cycle after id 2; `result_hit` = 1, `result_t` = 0x08000000, `result_id` = 1, `result_count` = 3.
- Rejections:
  - Samples: code 2 with t=0x01000000; code 1 with t=0xF0000000 (negative); code 1 with t=0x00020000 (below `T_MIN`); code 0 (last).
  - Required: `result_hit` = 0, `result_t` = 0x7FFFFFFF, `result_count` = 4.
- Tie handling:
  - Two code-1 samples with t=0x08000000, ids 5 then 6.
  - Required: `result_id` = 5; u/v taken from id 5 (u=0x08000000, v=0x08000000 when driven so).
- `ray_start` together with `hit_valid` (t=0x01000000, code 1):
  - Required: sample discarded and `count` = 0.
  - A following single sample t=0x20000000, last, gives `result_t` = 0x20000000, `result_count` = 1.
- `reset` low in ACCUM after 2 accepted samples:
  - Required: no `result_valid`, outputs at their reset values.
  - A subsequent normal ray returns correct results.
